// File: rtl/c880_resp_misr_if.sv
// Handshake/bus bundle between the self-test sequencer and the c880 response MISR.
//   master: drives start, num_patterns, expected_sig, resp_valid, resp;
//           observes busy, done, pass, signature, count.
//   slave : the MISR side (directions reversed).
interface c880_resp_misr_if #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_patterns;
    logic [WIDTH-1:0] expected_sig;
    logic             resp_valid;
    logic [WIDTH-1:0] resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] count;

    modport master (
        output start, num_patterns, expected_sig, resp_valid, resp,
        input  busy, done, pass, signature, count
    );

    modport slave (
        input  start, num_patterns, expected_sig, resp_valid, resp,
        output busy, done, pass, signature, count
    );
endinterface

// File: rtl/c880_resp_misr.sv
// c880 response compactor: folds the 26 c880 primary outputs into a 26-bit MISR over a
// programmed number of patterns, then compares the result against a golden signature.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   bus (slave)   : start/num_patterns/expected_sig run request, resp_valid/resp response
//                   stream, busy/done/pass/signature/count status (all registered)
module c880_resp_misr #(
    parameter int unsigned      WIDTH = 26,
    parameter int unsigned      CNT_W = 16,
    parameter logic [WIDTH-1:0] POLY  = 26'h0000047,
    parameter logic [WIDTH-1:0] SEED  = 26'h0000000
) (
    input logic              clk,
    input logic              rst,
    c880_resp_misr_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sig_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] num_q;
    logic [WIDTH-1:0] exp_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [WIDTH-1:0] sig_next;
    logic [CNT_W-1:0] cnt_inc;

    // One MISR step: shift left, fold the outgoing MSB back through the taps, absorb resp.
    always_comb begin
        sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ bus.resp;
        cnt_inc  = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sig_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                // DONE accepts a restart exactly like IDLE.
                StIdle, StDone: begin
                    if (bus.start) begin
                        sig_q <= SEED;
                        cnt_q <= '0;
                        exp_q <= bus.expected_sig;
                        if (bus.num_patterns != '0) begin
                            num_q   <= bus.num_patterns;
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end else begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (SEED == bus.expected_sig);
                        end
                    end
                end
                StRun: begin
                    if (bus.resp_valid) begin
                        sig_q <= sig_next;
                        cnt_q <= cnt_inc;
                        if (cnt_inc == num_q) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_next == exp_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
    assign bus.count     = cnt_q;

endmodule
